// File: rtl/hx8352_pkg.sv
// Shared definitions for the HX8352 panel init sequencer: ROM entry format,
// opcode encodings, FSM state encoding and the default delay guard.
package hx8352_pkg;

   localparam int ENTRY_W       = 19;
   localparam int ARG_W         = 16;
   localparam int GUARD_CYC_DEF = 3;

   typedef enum logic [2:0] {
      OP_CMD    = 3'd0,
      OP_DATA   = 3'd1,
      OP_DELAY  = 3'd2,
      OP_RST_LO = 3'd3,
      OP_RST_HI = 3'd4,
      OP_NOP5   = 3'd5,
      OP_NOP6   = 3'd6,
      OP_END    = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WRITE,
      S_DLY_ARM,
      S_DLY_GUARD,
      S_DLY_WAIT,
      S_DONE
   } state_e;

   function automatic logic [ENTRY_W-1:0] mk_entry(op_e op, logic [ARG_W-1:0] arg);
      return {op, arg};
   endfunction

endpackage

// File: rtl/hx8352_init_rom.sv
// Panel init table for the HX8352 sequencer; registered read, 1-cycle latency.
// Addresses past the end of the table read back as END.
module hx8352_init_rom
   import hx8352_pkg::*;
#(
   parameter int ROM_DEPTH = 64,
   parameter int AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
   input  logic               clk_1MHz,
   input  logic [AW-1:0]      addr,
   output logic [ENTRY_W-1:0] entry
);

   logic [ENTRY_W-1:0] entry_d;
   logic [ENTRY_W-1:0] entry_q;

   always_comb begin
      case (32'(addr))
         32'd0:   entry_d = mk_entry(OP_RST_LO, 16'h0000);
         32'd1:   entry_d = mk_entry(OP_DELAY,  16'd10);
         32'd2:   entry_d = mk_entry(OP_RST_HI, 16'h0000);
         32'd3:   entry_d = mk_entry(OP_DELAY,  16'd5);
         32'd4:   entry_d = mk_entry(OP_CMD,    16'h0022);
         32'd5:   entry_d = mk_entry(OP_DATA,   16'h1234);
         32'd6:   entry_d = mk_entry(OP_DELAY,  16'd0);
         32'd7:   entry_d = mk_entry(OP_NOP5,   16'hBEEF);
         32'd8:   entry_d = mk_entry(OP_DELAY,  16'd100);
         32'd9:   entry_d = mk_entry(OP_NOP6,   16'h5A5A);
         32'd10:  entry_d = mk_entry(OP_CMD,    16'h0001);
         32'd11:  entry_d = mk_entry(OP_DATA,   16'h0003);
         default: entry_d = mk_entry(OP_END,    16'h0000);
      endcase
   end

   always_ff @(posedge clk_1MHz) begin
      entry_q <= entry_d;
   end

   assign entry = entry_q;

endmodule

// File: rtl/hx8352_init_seq.sv
// HX8352 init sequencer: walks the init ROM, issuing bus writes, timed delays
// and panel reset control. All outputs are registered.
module hx8352_init_seq
   import hx8352_pkg::*;
#(
   parameter int ROM_DEPTH = 64,
   parameter int GUARD_CYC = GUARD_CYC_DEF
) (
   input  logic        clk_1MHz,
   input  logic        rst,
   input  logic        start,
   input  logic        delay_done,
   output logic        delay_step,
   output logic [15:0] delay_us,
   output logic        wr_req,
   output logic        wr_dc,
   output logic [15:0] wr_data,
   input  logic        wr_ack,
   output logic        lcd_rst_n,
   output logic        busy,
   output logic        init_done
);

   localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

   state_e             state_d, state_q;
   logic [AW-1:0]      addr_d, addr_q;
   logic [7:0]         cnt_d, cnt_q;
   logic               start_q;
   logic               delay_step_d, delay_step_q;
   logic [15:0]        delay_us_d, delay_us_q;
   logic               wr_req_d, wr_req_q;
   logic               wr_dc_d, wr_dc_q;
   logic [15:0]        wr_data_d, wr_data_q;
   logic               lcd_rst_n_d, lcd_rst_n_q;
   logic               busy_d, busy_q;
   logic               init_done_d, init_done_q;
   logic [ENTRY_W-1:0] entry;
   op_e                op;
   logic [15:0]        arg;
   logic               adv;
   logic               fin;

   hx8352_init_rom #(.ROM_DEPTH(ROM_DEPTH), .AW(AW)) u_rom (
      .clk_1MHz (clk_1MHz),
      .addr     (addr_q),
      .entry    (entry)
   );

   assign op  = op_e'(entry[18:16]);
   assign arg = entry[15:0];

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      delay_step_d = delay_step_q;
      delay_us_d   = delay_us_q;
      wr_req_d     = wr_req_q;
      wr_dc_d      = wr_dc_q;
      wr_data_d    = wr_data_q;
      lcd_rst_n_d  = lcd_rst_n_q;
      busy_d       = busy_q;
      init_done_d  = init_done_q;
      adv          = 1'b0;
      fin          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !start_q) begin
               state_d     = S_FETCH;
               addr_d      = '0;
               busy_d      = 1'b1;
               init_done_d = 1'b0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_CMD, OP_DATA: begin
                  wr_req_d  = 1'b1;
                  wr_dc_d   = entry[16];
                  wr_data_d = arg;
                  state_d   = S_WRITE;
               end
               OP_DELAY: begin
                  if (arg == 16'd0) begin
                     adv = 1'b1;
                  end else begin
                     delay_us_d = arg;
                     cnt_d      = 8'd2;
                     state_d    = S_DLY_ARM;
                  end
               end
               OP_RST_LO: begin
                  lcd_rst_n_d = 1'b0;
                  adv         = 1'b1;
               end
               OP_RST_HI: begin
                  lcd_rst_n_d = 1'b1;
                  adv         = 1'b1;
               end
               OP_END:  fin = 1'b1;
               default: adv = 1'b1;
            endcase
         end
         S_WRITE: begin
            if (wr_ack) begin
               wr_req_d = 1'b0;
               adv      = 1'b1;
            end
         end
         // First ARM cycle only presents delay_us; step is high for the next two.
         S_DLY_ARM: begin
            if (cnt_q == 8'd0) begin
               delay_step_d = 1'b0;
               cnt_d        = 8'(GUARD_CYC - 1);
               state_d      = (GUARD_CYC == 0) ? S_DLY_WAIT : S_DLY_GUARD;
            end else begin
               delay_step_d = 1'b1;
               cnt_d        = cnt_q - 8'd1;
            end
         end
         S_DLY_GUARD: begin
            if (cnt_q == 8'd0) begin
               state_d = S_DLY_WAIT;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DLY_WAIT: begin
            if (delay_done) begin
               adv = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Executing the last ROM slot ends the sequence instead of wrapping.
      if (adv) begin
         if (addr_q == LAST_ADDR) begin
            fin = 1'b1;
         end else begin
            addr_d  = addr_q + AW'(1);
            state_d = S_FETCH;
         end
      end
      if (fin) begin
         state_d      = S_DONE;
         busy_d       = 1'b0;
         init_done_d  = 1'b1;
         wr_req_d     = 1'b0;
         delay_step_d = 1'b0;
      end
   end

   always_ff @(posedge clk_1MHz or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         start_q      <= 1'b0;
         delay_step_q <= 1'b0;
         delay_us_q   <= '0;
         wr_req_q     <= 1'b0;
         wr_dc_q      <= 1'b0;
         wr_data_q    <= '0;
         lcd_rst_n_q  <= 1'b1;
         busy_q       <= 1'b0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         start_q      <= start;
         delay_step_q <= delay_step_d;
         delay_us_q   <= delay_us_d;
         wr_req_q     <= wr_req_d;
         wr_dc_q      <= wr_dc_d;
         wr_data_q    <= wr_data_d;
         lcd_rst_n_q  <= lcd_rst_n_d;
         busy_q       <= busy_d;
         init_done_q  <= init_done_d;
      end
   end

   assign delay_step = delay_step_q;
   assign delay_us   = delay_us_q;
   assign wr_req     = wr_req_q;
   assign wr_dc      = wr_dc_q;
   assign wr_data    = wr_data_q;
   assign lcd_rst_n  = lcd_rst_n_q;
   assign busy       = busy_q;
   assign init_done  = init_done_q;

endmodule

// File: tb/tb_hx8352_init_seq.sv
// Bench for hx8352_init_seq: bus-writer and delay-timer responders, event logs,
// and a table-walk reference model of the panel init sequence.
`timescale 1ns/1ps
module tb_hx8352_init_seq;

   localparam int G = 3;

   logic        clk_1MHz = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        delay_done = 1'b1;
   logic        delay_step;
   logic [15:0] delay_us;
   logic        wr_req, wr_dc, wr_ack = 1'b0;
   logic [15:0] wr_data;
   logic        lcd_rst_n, busy, init_done;

   logic        start_x = 1'b0, delay_done_x = 1'b1, wr_ack_x = 1'b0;
   logic        delay_step_x, wr_req_x, wr_dc_x, lcd_rst_n_x, busy_x, init_done_x;
   logic [15:0] delay_us_x, wr_data_x;

   hx8352_init_seq #(.ROM_DEPTH(64), .GUARD_CYC(G)) dut (
      .clk_1MHz(clk_1MHz), .rst(rst), .start(start), .delay_done(delay_done),
      .delay_step(delay_step), .delay_us(delay_us), .wr_req(wr_req), .wr_dc(wr_dc),
      .wr_data(wr_data), .wr_ack(wr_ack), .lcd_rst_n(lcd_rst_n), .busy(busy),
      .init_done(init_done));

   // Four-entry ROM: exercises exhaustion without an END opcode.
   hx8352_init_seq #(.ROM_DEPTH(4), .GUARD_CYC(G)) dut_x (
      .clk_1MHz(clk_1MHz), .rst(rst), .start(start_x), .delay_done(delay_done_x),
      .delay_step(delay_step_x), .delay_us(delay_us_x), .wr_req(wr_req_x), .wr_dc(wr_dc_x),
      .wr_data(wr_data_x), .wr_ack(wr_ack_x), .lcd_rst_n(lcd_rst_n_x), .busy(busy_x),
      .init_done(init_done_x));

   always #500 clk_1MHz = ~clk_1MHz;

   int nassert = 0;
   int nfail = 0;

   // Reference copy of the panel init table.
   int tbl_op[13]  = '{3, 2, 4, 2, 0, 1, 2, 5, 2, 6, 0, 1, 7};
   int tbl_arg[13] = '{0, 10, 0, 5, 'h22, 'h1234, 0, 'hBEEF, 100, 'h5A5A, 1, 3, 0};
   logic [16:0] exp_w[$];
   int          exp_d[$];
   logic        exp_rst;

   // Observed event logs.
   int          cyc = 0;
   logic [16:0] wlog[$];
   int          acyc[$], wrise[$], slog[$], srise[$];
   int          ws_err, sp_err, sw_err, busy_rises, low_len, fall_cyc;
   int          x_steps = 0, x_wr_seen = 0;
   int          ack_cnt = -1, swidth = 0, tmr = 0;
   logic [16:0] wcap;
   logic        wr_prev = 0, step_prev = 0, lcd_prev = 1, busy_prev = 0, xstep_prev = 0;
   logic [15:0] us_prev = 0;
   bit          timer_mode = 0, ack_rand = 0;
   int          ack_fixed = 4;

   always @(negedge clk_1MHz) begin
      cyc++;
      wr_ack = 1'b0;
      if (wr_req && !wr_prev) begin
         ack_cnt = ack_rand ? int'($urandom_range(0, 6)) : ack_fixed;
         wcap = {wr_dc, wr_data};
         wrise.push_back(cyc);
      end
      if (wr_req && !rst) begin
         if ({wr_dc, wr_data} !== wcap) ws_err++;
         if (ack_cnt == 0) begin
            wr_ack = 1'b1;
            wlog.push_back(wcap);
            acyc.push_back(cyc);
         end
         ack_cnt--;
      end
      if (delay_step && !step_prev) begin
         srise.push_back(cyc);
         slog.push_back(int'(delay_us));
         if (delay_us !== us_prev) sp_err++;
         swidth = 1;
      end else if (delay_step) begin
         swidth++;
      end else if (step_prev && swidth != 2) begin
         sw_err++;
      end
      if (rst) begin
         tmr = 0;
         delay_done = 1'b1;
      end else begin
         if (timer_mode && delay_step && !step_prev) tmr = int'(delay_us);
         if (tmr > 0) begin
            delay_done = 1'b0;
            tmr--;
         end else begin
            delay_done = 1'b1;
         end
      end
      if (!lcd_rst_n && lcd_prev) fall_cyc = cyc;
      if (lcd_rst_n && !lcd_prev) low_len = cyc - fall_cyc;
      if (busy && !busy_prev) busy_rises++;
      if (delay_step_x && !xstep_prev) x_steps++;
      if (wr_req_x) x_wr_seen++;
      wr_prev = wr_req; step_prev = delay_step; us_prev = delay_us;
      lcd_prev = lcd_rst_n; busy_prev = busy; xstep_prev = delay_step_x;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_1MHz);
   endtask

   task automatic pulse_start(input int w);
      @(negedge clk_1MHz);
      start = 1'b1;
      cycles(w);
      start = 1'b0;
   endtask

   task automatic clear_logs();
      wlog.delete(); acyc.delete(); wrise.delete(); slog.delete(); srise.delete();
      ws_err = 0; sp_err = 0; sw_err = 0; busy_rises = 0; low_len = 0;
   endtask

   task automatic wait_done(input int bound, input string tag);
      for (int i = 0; i < bound && init_done !== 1'b1; i++) @(negedge clk_1MHz);
      check(tag, init_done, 1'b1);
   endtask

   // Walk the table as the sequencer should: stop at END or after the last slot.
   task automatic build_exp(input int depth);
      exp_w.delete(); exp_d.delete(); exp_rst = 1'b1;
      for (int i = 0; i < depth; i++) begin
         if (i >= 13) break;
         if (tbl_op[i] == 7) break;
         case (tbl_op[i])
            0, 1: exp_w.push_back({1'(tbl_op[i] & 1), 16'(tbl_arg[i])});
            2: if (tbl_arg[i] != 0) exp_d.push_back(tbl_arg[i]);
            3: exp_rst = 1'b0;
            4: exp_rst = 1'b1;
            default: ;
         endcase
      end
   endtask

   task automatic check_run(input string tag);
      check({tag, "_nwr"}, wlog.size(), exp_w.size());
      if (wlog.size() == exp_w.size())
         foreach (exp_w[i]) check($sformatf("%s_wr%0d", tag, i), wlog[i], exp_w[i]);
      check({tag, "_ndly"}, slog.size(), exp_d.size());
      if (slog.size() == exp_d.size())
         foreach (exp_d[i]) check($sformatf("%s_dly%0d", tag, i), slog[i], exp_d[i]);
      check({tag, "_wr_stable"}, ws_err, 0);
      check({tag, "_us_setup"}, sp_err, 0);
      check({tag, "_step_width"}, sw_err, 0);
      check({tag, "_busy_once"}, busy_rises, 1);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_wr_req_end"}, wr_req, 1'b0);
      check({tag, "_step_end"}, delay_step, 1'b0);
      check({tag, "_lcd_end"}, lcd_rst_n, exp_rst);
      // DATA ack -> DELAY0, NOP5, DELAY100 each fetch+decode, then 1 setup cycle.
      if (acyc.size() >= 2 && srise.size() >= 3)
         check({tag, "_dly0_gap"}, srise[2] - acyc[1], 3 * 2 + 2);
   endtask

   initial begin
      build_exp(64);
      #100 rst = 1'b1;
      #100;
      check("rst_busy", busy, 1'b0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_wr_req", wr_req, 1'b0);
      check("rst_wr_dc", wr_dc, 1'b0);
      check("rst_wr_data", wr_data, 16'h0);
      check("rst_step", delay_step, 1'b0);
      check("rst_us", delay_us, 16'h0);
      check("rst_lcd", lcd_rst_n, 1'b1);
      cycles(3);
      rst = 1'b0;
      cycles(3);
      check("idle_busy", busy, 1'b0);

      // Run A: timer reports done throughout, fixed ack latency, extra start while busy.
      timer_mode = 0; ack_rand = 0; ack_fixed = 4;
      clear_logs();
      pulse_start(2);
      check("a_busy_start", busy, 1'b1);
      cycles($urandom_range(15, 30));
      check("a_busy_mid", busy, 1'b1);
      pulse_start(3);
      wait_done(2000, "a_done");
      check_run("a");
      if (wrise.size() >= 3 && srise.size() >= 3)
         check("a_guard_exit", wrise[2] - srise[2], (2 + G + 1) + 4);

      // Run B: restart after init_done, timer model, random ack latency.
      timer_mode = 1; ack_rand = 1;
      clear_logs();
      pulse_start($urandom_range(1, 4));
      check("b_init_done_clr", init_done, 1'b0);
      check("b_busy_start", busy, 1'b1);
      wait_done(2000, "b_done");
      check_run("b");
      check("b_lcd_low", (low_len >= 10 + G), 1'b1);
      if (wrise.size() >= 3 && srise.size() >= 3)
         check("b_dly100_exit", (wrise[2] - srise[2] >= 101) && (wrise[2] - srise[2] <= 107), 1'b1);

      // Run C: reset while waiting on the 10 us delay.
      clear_logs();
      pulse_start(1);
      for (int i = 0; i < 300 && slog.size() < 1; i++) @(negedge clk_1MHz);
      check("c_reach_dly", slog.size() >= 1, 1'b1);
      cycles(6);
      check("c_lcd_low_pre", lcd_rst_n, 1'b0);
      #200 rst = 1'b1;
      #1;
      check("c_rst_busy", busy, 1'b0);
      check("c_rst_init_done", init_done, 1'b0);
      check("c_rst_us", delay_us, 16'h0);
      check("c_rst_lcd", lcd_rst_n, 1'b1);
      check("c_rst_step", delay_step, 1'b0);
      check("c_rst_wr_req", wr_req, 1'b0);
      cycles(2);
      rst = 1'b0;
      cycles(10);
      check("c_wait_start", busy, 1'b0);
      check("c_no_done", init_done, 1'b0);
      clear_logs();
      pulse_start(2);
      wait_done(2000, "c_done");
      check_run("c");

      // Run D: four-slot ROM ends by exhaustion.
      build_exp(4);
      @(negedge clk_1MHz);
      start_x = 1'b1;
      cycles(2);
      start_x = 1'b0;
      for (int i = 0; i < 500 && init_done_x !== 1'b1; i++) @(negedge clk_1MHz);
      check("x_done", init_done_x, 1'b1);
      cycles(20);
      check("x_steps", x_steps, exp_d.size());
      check("x_no_writes", x_wr_seen, exp_w.size());
      check("x_lcd", lcd_rst_n_x, exp_rst);
      check("x_busy", busy_x, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule

// File: doc/hx8352_init_seq.md
HX8352_INIT_SEQ -- requirements
Module: hx8352_init_seq

Interface
REQ-001 Parameter ROM_DEPTH, default 64: number of init-ROM entries; the address is clog2(ROM_DEPTH) bits wide.
REQ-002 Parameter GUARD_CYC, default 3: cycles after delay_step rises during which delay_done is ignored.
REQ-003 clk_1MHz  in  1  system clock, 1 us period.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  rising edge starts the init sequence; ignored while busy.
REQ-006 delay_done  in  1  delay-timer done flag; high = idle or expired.
REQ-007 delay_step  out  1  delay-timer start request, rising-edge significant.
REQ-008 delay_us  out  16  delay length in us, presented to the delay timer.
REQ-009 wr_req  out  1  bus-writer request, level.
REQ-010 wr_dc  out  1  0 = command (index) write, 1 = data write.
REQ-011 wr_data  out  16  bus-writer payload.
REQ-012 wr_ack  in  1  bus-writer single-cycle acknowledge.
REQ-013 lcd_rst_n  out  1  panel hardware reset, active-low.
REQ-014 busy  out  1  high from sequence start until END.
REQ-015 init_done  out  1  sticky high after END; cleared only by rst or a new start.

Function
REQ-016 The block SHALL read 19-bit entries {op[2:0], arg[15:0]} from sub-module hx8352_init_rom using a registered read with 1-cycle latency.
REQ-017 Opcodes SHALL be: 0 CMD, 1 DATA, 2 DELAY, 3 RST_LO, 4 RST_HI, 7 END; opcodes 5 and 6 SHALL be NOPs that advance the address.
REQ-018 The FSM states SHALL be IDLE, FETCH, DECODE, WRITE, DLY_ARM, DLY_GUARD, DLY_WAIT and DONE.
REQ-019 IDLE -> FETCH occurs on a start rising edge (start & ~start_q), with addr=0, busy=1 and init_done=0.
REQ-020 FETCH SHALL last 1 cycle for the ROM read, then go to DECODE.
REQ-021 In DECODE, CMD/DATA SHALL set wr_dc=op[0] and wr_data=arg, assert wr_req, and go to WRITE.
REQ-022 In WRITE, wr_req, wr_dc and wr_data SHALL hold stable until wr_ack; in the ack cycle wr_req SHALL drop, addr SHALL increment, and the FSM SHALL go to FETCH.
REQ-023 In DECODE, a DELAY with arg=0 SHALL be treated as a NOP (no step issued); with arg>0 the block SHALL drive delay_us=arg and go to DLY_ARM.
REQ-024 delay_us SHALL be valid for at least 1 cycle before delay_step rises and SHALL be held until DLY_WAIT exits.
REQ-025 DLY_ARM SHALL drive delay_step=1 for exactly 2 cycles, then go to DLY_GUARD.
REQ-026 DLY_GUARD SHALL hold delay_step=0 and ignore delay_done for GUARD_CYC cycles, then go to DLY_WAIT.
REQ-027 DLY_WAIT SHALL wait for delay_done=1, then increment addr and go to FETCH.
REQ-028 RST_LO/RST_HI SHALL set lcd_rst_n to 0/1 in the DECODE cycle and increment addr, going directly to FETCH.
REQ-029 END, or addr reaching ROM_DEPTH-1 after execution, SHALL transition to DONE: busy=0, init_done=1, all requests low, then IDLE.
REQ-030 addr SHALL never wrap; exhausting the ROM SHALL behave as END.
REQ-031 A start edge while busy SHALL be ignored; a start edge from IDLE with init_done=1 SHALL restart the sequence at addr 0.
REQ-032 wr_ack outside WRITE and delay_done transitions outside DLY_WAIT SHALL have no effect.
REQ-033 The block SHALL have no timeout: an absent wr_ack or delay_done stalls the FSM indefinitely.

Reset
REQ-034 rst SHALL force, asynchronously: state=IDLE, addr=0, start_q=0, delay_step=0, delay_us=0, wr_req=0, wr_dc=0, wr_data=0, lcd_rst_n=1, busy=0, init_done=0.
REQ-035 An rst asserted mid-sequence SHALL abandon the sequence without completing it; after release the block SHALL wait for a new start edge.

Structure
REQ-036 The opcode encodings, ROM entry width (19) and the default GUARD_CYC SHALL live in a shared package/include, hx8352_pkg.
REQ-037 The ROM contents SHALL be a single sub-module, hx8352_init_rom (clk, addr -> entry), holding the panel init table; the FSM SHALL contain no table data.
REQ-038 The implementation SHALL be a single clock domain (clk_1MHz) with all outputs registered.

Verification
REQ-039 ROM {RST_LO; DELAY 10; RST_HI; DELAY 5; END} -> lcd_rst_n low for at least 10+GUARD cycles, two 2-cycle delay_step pulses carrying delay_us=10 and 5, then init_done=1.
REQ-040 ROM {CMD 0x0022; DATA 0x1234; END} with wr_ack delayed 4 cycles -> wr_dc/wr_data held stable (0/0x0022, then 1/0x1234) until ack, exactly two writes, then busy=0.
REQ-041 DELAY 0 entry -> no delay_step pulse; the next entry is decoded 2 cycles later.
REQ-042 delay_done held at 1 throughout a DELAY 100 -> the FSM leaves DLY_WAIT exactly 2+GUARD_CYC+1 cycles after step rises (guard honoured); with a behavioural timer model, exit occurs at 100 us +/- 3 cycles.
REQ-043 rst pulsed during DLY_WAIT -> all outputs at reset values immediately; a subsequent start edge re-executes the sequence from addr 0.
REQ-044 A second start edge while busy -> ignored, producing no restart; a start edge after init_done -> a full re-run, with init_done cleared at the start.
